// File: rtl/led_bar_sequencer.sv
// +--------------------------------------------------------------------------+
// | led_bar_sequencer: steps a 16-LED bar through one of four 16-step        |
// | patterns at a programmable rate. Optional wrap-around: LED_SEQ_LOOP_EN.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module led_bar_sequencer #(
  parameter int unsigned TICK_DIV = 80000000,
  parameter int unsigned CNT_W    = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        pause,
  input  logic        abort,
  input  logic        loop,
  output logic        busy,
  output logic        done,
  output logic [3:0]  step,
  output logic [15:0] led
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_pause = 2'd2;
  localparam logic [1:0] c_st_hold  = 2'd3;

  localparam logic [CNT_W-1:0] c_tick_last = CNT_W'(TICK_DIV - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_step;
  logic [1:0]       r_mode;
  logic             r_done;
  logic [4:0]       w_step_p1;

`ifndef LED_SEQ_LOOP_EN
  logic w_unused_loop;
  assign w_unused_loop = loop;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_step  <= 4'd0;
      r_mode  <= 2'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= c_st_idle;
        r_cnt   <= '0;
        r_step  <= 4'd0;
      end else begin
        case (r_state)
          c_st_idle, c_st_hold: begin
            if (start) begin
              r_state <= c_st_run;
              r_mode  <= mode;
              r_cnt   <= '0;
              r_step  <= 4'd0;
            end
          end
          c_st_run: begin
            if (pause) begin
              r_state <= c_st_pause;
            end else if (r_cnt == c_tick_last) begin
              r_cnt <= '0;
              if (r_step != 4'd15) begin
                r_step <= r_step + 4'd1;
              end else begin
                r_done <= 1'b1;
`ifdef LED_SEQ_LOOP_EN
                if (loop) r_step <= 4'd0;
                else      r_state <= c_st_hold;
`else
                r_state <= c_st_hold;
`endif
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          c_st_pause: begin
            if (!pause) r_state <= c_st_run;
          end
          default: r_state <= c_st_idle;
        endcase
      end
    end
  end

  assign busy = (r_state == c_st_run) || (r_state == c_st_pause);
  assign done = r_done;
  assign step = r_step;
  assign w_step_p1 = {1'b0, r_step} + 5'd1;

  // LEDs decode only registered state so the pins never glitch on input changes.
  always_comb begin
    led = 16'h0000;
    if (r_state != c_st_idle) begin
      case (r_mode)
        2'd0:    led = 16'hFFFF >> (4'd15 - r_step);
        2'd1:    led = ~(16'hFFFF >> w_step_p1);
        2'd2:    led = 16'h0001 << r_step;
        default: led = 16'hFFFF >> w_step_p1;
      endcase
    end
  end

endmodule

`default_nettype wire
